// File: rtl/snd_pkg.sv
// Shared definitions for the sound-effect voice allocator.
package snd_pkg;

  localparam int unsigned NUM_SE    = 4;
  localparam int unsigned LEN_W_DEF = 24;
  localparam int unsigned ID_W_DEF  = 4;

  typedef enum logic [1:0] {
    SE_IDLE  = 2'd0,
    SE_START = 2'd1,
    SE_PLAY  = 2'd2
  } se_state_e;

endpackage

// File: rtl/snd_se_voice.sv
// One SE channel: lifecycle FSM, remaining-frame counter and age counter.
module snd_se_voice
  import snd_pkg::*;
#(
  parameter int unsigned LEN_W = LEN_W_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic [LEN_W-1:0] len,
  input  logic             consume,
  input  logic             stop,
  output logic             start,
  output logic             sel,
  output logic             busy,
  output logic [LEN_W-1:0] age
);

  se_state_e        state_q;
  logic [LEN_W-1:0] rem_q;
  logic [LEN_W-1:0] age_q;

  // Channel FSM with counters; stop beats load, load (allocate or steal) beats playback.
  always_ff @(posedge CLK) begin
    if (RST || stop) begin
      state_q <= SE_IDLE;
      rem_q   <= '0;
      age_q   <= '0;
    end else if (load) begin
      state_q <= SE_START;
      rem_q   <= len;
      age_q   <= '0;
    end else begin
      case (state_q)
        SE_START: state_q <= SE_PLAY;
        SE_PLAY: begin
          if (consume) begin
            rem_q <= rem_q - LEN_W'(1);
            if (!(&age_q)) age_q <= age_q + LEN_W'(1);
            // Last frame consumed: never select the channel again for this effect.
            if (rem_q == LEN_W'(1)) state_q <= SE_IDLE;
          end
        end
        default: state_q <= SE_IDLE;
      endcase
    end
  end

  // Outputs decode directly from the state register, so they are glitch-free.
  always_comb begin
    start = (state_q == SE_START);
    sel   = (state_q == SE_PLAY);
    busy  = (state_q != SE_IDLE);
    age   = age_q;
  end

endmodule

// File: rtl/snd_se_alloc.sv
// SE voice allocator: picks a free or oldest channel per request and gates mixer reads.
module snd_se_alloc
  import snd_pkg::*;
#(
  parameter int unsigned LEN_W = LEN_W_DEF,
  parameter int unsigned ID_W  = ID_W_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ_VALID,
  input  logic [ID_W-1:0]  REQ_ID,
  input  logic [LEN_W-1:0] REQ_LEN,
  output logic             REQ_READY,
  input  logic             STOP_ALL,
  input  logic             FIFO_RD,
  input  logic [3:0]       SE_FIFO_VALID,
  output logic [3:0]       CH_START,
  output logic [ID_W-1:0]  CH_START_ID,
  output logic [3:0]       M_SE_SELECT,
  output logic [3:0]       SE_BUSY
);

  logic [NUM_SE-1:0] ch_start;
  logic [NUM_SE-1:0] ch_sel;
  logic [NUM_SE-1:0] ch_busy;
  logic [NUM_SE-1:0] ch_load;
  logic [NUM_SE-1:0] ch_consume;
  logic [LEN_W-1:0]  ch_age [NUM_SE];
  logic [1:0]        tgt;
  logic              found_idle;
  logic              accept;
  logic [ID_W-1:0]   start_id_q;

  // Zero-length requests are accepted but allocate nothing.
  always_comb begin
    REQ_READY = ~STOP_ALL & ~RST;
    accept    = REQ_VALID & REQ_READY & (REQ_LEN != '0);
  end

  // Target: lowest idle channel, else the oldest busy one (strict compare keeps lowest on ties).
  always_comb begin
    found_idle = 1'b0;
    tgt        = 2'd0;
    for (int i = 0; i < NUM_SE; i++) begin
      if (!ch_busy[i] && !found_idle) begin
        found_idle = 1'b1;
        tgt        = 2'(i);
      end
    end
    if (!found_idle) begin
      tgt = 2'd0;
      for (int i = 1; i < NUM_SE; i++) begin
        if (ch_age[i] > ch_age[tgt]) tgt = 2'(i);
      end
    end
  end

  // Id of the most recent allocation; held while no start pulse is active.
  always_ff @(posedge CLK) begin
    if (RST) begin
      start_id_q <= '0;
    end else if (accept) begin
      start_id_q <= REQ_ID;
    end
  end

  for (genvar g = 0; g < NUM_SE; g++) begin : g_voice
    // A frame counts only when the mixer actually reads real data from this channel.
    always_comb begin
      ch_load[g]    = accept & (tgt == 2'(g));
      ch_consume[g] = FIFO_RD & SE_FIFO_VALID[g] & ch_sel[g];
    end

    snd_se_voice #(
      .LEN_W(LEN_W)
    ) u_voice (
      .CLK    (CLK),
      .RST    (RST),
      .load   (ch_load[g]),
      .len    (REQ_LEN),
      .consume(ch_consume[g]),
      .stop   (STOP_ALL),
      .start  (ch_start[g]),
      .sel    (ch_sel[g]),
      .busy   (ch_busy[g]),
      .age    (ch_age[g])
    );
  end

  // Drive the mixer and fetcher interfaces.
  always_comb begin
    CH_START    = ch_start;
    CH_START_ID = start_id_q;
    M_SE_SELECT = ch_sel;
    SE_BUSY     = ch_busy;
  end

endmodule

// File: doc/snd_se_alloc.md
Name: snd_se_alloc

Overview:
- Sound-effect voice allocator and sequencer for the four SE channels of the mixer.
- Accepts one SE play request per cycle from game logic and assigns it to a free SE channel, or steals the oldest voice when all four are busy.
- Pulses a start command to that channel's sample fetcher.
- Counts the samples the mixer actually consumes and drives M_SE_SELECT so each channel is read only while it is playing.
- Replaces the static M_SE_SELECT field from snd_regctrl.

Parameters:
- LEN_W, 24, width of the sample-count length field (stereo frames).
- ID_W, 4, width of the sound-effect identifier.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous active-high reset.
- REQ_VALID  in  1  play request.
- REQ_ID  in  ID_W  sound-effect id to play.
- REQ_LEN  in  LEN_W  number of frames in the effect.
- REQ_READY  out  1  request accepted when high together with REQ_VALID.
- STOP_ALL  in  1  abort all SE voices.
- FIFO_RD  in  1  frame read strobe from snd_buffer (the same strobe the mixer sees).
- SE_FIFO_VALID  in  4  VALID of SE1..SE4 FIFOs, bit0 = SE1.
- CH_START  out  4  one-cycle start pulse per channel to the SE fetcher.
- CH_START_ID  out  ID_W  id for the channel pulsed on CH_START.
- M_SE_SELECT  out  4  per-channel read enable to snd_mix.
- SE_BUSY  out  4  channel allocated (START or PLAY).

Behaviour:
- Reset: all channels IDLE. CH_START=0, CH_START_ID=0, M_SE_SELECT=0, SE_BUSY=0, REQ_READY=0 during RST. All counters clear.
- REQ_READY = ~STOP_ALL (registered-free, combinational). A request is accepted on a cycle where REQ_VALID & REQ_READY.
- Per-channel FSM:
  - IDLE -> START on allocation.
  - START -> PLAY after one cycle.
  - PLAY -> IDLE when the last frame is consumed.
  - Any state -> START on steal.
  - Any state -> IDLE on STOP_ALL.
- Per-channel registers: remaining count REM (LEN_W bits) and age AGE (LEN_W bits, saturating).
- Allocation uses registered state only:
  - Target is the lowest-index IDLE channel.
  - If none is IDLE, target is the channel with the largest AGE. Ties go to the lowest index.
  - A channel finishing in the same cycle is not yet free, so it is stolen only if it wins the age compare.
- Timing from an accept at cycle T:
  - At T+1: the target is in START, CH_START[i]=1, CH_START_ID=REQ_ID (latched at T), REM=REQ_LEN, AGE=0, SE_BUSY[i]=1, M_SE_SELECT[i]=0.
  - At T+2: PLAY, M_SE_SELECT[i]=1.
- CH_START is one-hot or zero. CH_START_ID holds its last value when CH_START=0.
- Consumption: in PLAY, a frame is consumed in a cycle where FIFO_RD & SE_FIFO_VALID[i] & M_SE_SELECT[i].
  - On each consumed frame, REM decrements and AGE increments (saturating at all-ones).
  - FIFO_RD while VALID is low does not count (the mixer outputs silence).
- End of effect: when a frame is consumed with REM==1, the next cycle is IDLE, M_SE_SELECT[i]=0, SE_BUSY[i]=0. The channel is never selected for a frame past REQ_LEN.
- REQ_LEN==0: the request is accepted and discarded. No channel changes and no CH_START pulse.
- Steal mid-play: the stolen channel goes to START. M_SE_SELECT[i] drops for that START cycle, and the fetcher flushes on CH_START.
- STOP_ALL: every channel goes to IDLE next cycle and all outputs drop to 0. STOP_ALL has priority over a same-cycle request, because REQ_READY=0.
- Reset mid-play behaves identically to STOP_ALL plus clearing CH_START_ID.
- One request per cycle maximum. Back-to-back accepts target different channels, because allocation sees the START state at T+1.

Decomposition:
- Package snd_pkg holds:
  - NUM_SE=4;
  - the channel state encoding SE_IDLE=2'd0, SE_START=2'd1, SE_PLAY=2'd2;
  - the default LEN_W and ID_W.
- Sub-module snd_se_voice, instantiated four times, contains one channel's FSM, REM, AGE, and its select/busy/start outputs. Inputs are load, len, consume and stop.
- The top level contains the free/oldest selection logic and the request latch.

Test Plan:
- Reset, then REQ id=3 len=4 with FIFO_RD and all VALID high every cycle:
  - CH_START=0001 and CH_START_ID=3 at T+1.
  - M_SE_SELECT=0001 from T+2 to T+5.
  - 0000 at T+6, and exactly 4 selected reads.
- Four back-to-back requests (len=100 each): CH_START pulses 0001, 0010, 0100, 1000 on consecutive cycles, and SE_BUSY reaches 1111.
- All busy with AGE values of 50/80/80/10 and a fifth request id=9: SE2 (bit1) is stolen, CH_START=0010 with id 9, and its select drops for one cycle then re-asserts.
- SE_FIFO_VALID[0]=0 for 3 of the reads on a len=5 channel: the channel stays selected until 5 valid reads have occurred.
- STOP_ALL raised during play with a simultaneous REQ: REQ_READY=0, all outputs are 0 next cycle, and no CH_START pulse.
- REQ len=0: REQ_READY=1 and the request is accepted, but CH_START stays 0000 and SE_BUSY is unchanged.
